// File: rtl/inv_shift_rows_serial.sv
// Byte-serial AES (Inv)ShiftRows stage with two 128-bit ping-pong buffers.
// Bytes arrive column-major (stream byte k = state[127-8k -: 8]) and leave
// permuted; one buffer fills while the other drains for 1 byte/cycle.
module inv_shift_rows_serial #(
  parameter bit INVERSE = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_byte,
  output logic       out_last
);

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_FILLING,
    BUF_FULL,
    BUF_DRAINING
  } buf_state_t;

  buf_state_t   r_state     [2];
  buf_state_t   w_state_nxt [2];
  logic [127:0] r_buf       [2];
  logic         r_wr_sel;
  logic         r_rd_sel;
  logic [3:0]   r_wr_cnt;
  logic [3:0]   r_rd_cnt;

  logic [1:0]   w_full;
  logic         w_wr_fire;
  logic         w_rd_fire;
  logic         w_wr_last;
  logic         w_rd_last;
  logic [1:0]   w_src_col;
  logic [3:0]   w_src;
  logic [6:0]   w_wr_lsb;
  logic [6:0]   w_rd_lsb;

  // Per-buffer lifecycle; a buffer can never be written and read in the same
  // cycle because writes need it not-full and reads need it full.
  function automatic buf_state_t buf_next(
    input buf_state_t cur,
    input logic       wr_hit,
    input logic       rd_hit
  );
    buf_next = cur;
    if (wr_hit) buf_next = w_wr_last ? BUF_FULL  : BUF_FILLING;
    if (rd_hit) buf_next = w_rd_last ? BUF_EMPTY : BUF_DRAINING;
  endfunction

  // Handshakes, source-byte selection and buffer next-state.
  always_comb begin
    w_full[0]  = (r_state[0] == BUF_FULL) || (r_state[0] == BUF_DRAINING);
    w_full[1]  = (r_state[1] == BUF_FULL) || (r_state[1] == BUF_DRAINING);
    in_ready   = !w_full[r_wr_sel];
    out_valid  = w_full[r_rd_sel];
    out_last   = out_valid && (r_rd_cnt == 4'd15);
    w_wr_fire  = in_valid && in_ready;
    w_rd_fire  = out_valid && out_ready;
    w_wr_last  = (r_wr_cnt == 4'd15);
    w_rd_last  = (r_rd_cnt == 4'd15);
    // Row = cnt[1:0], column = cnt[3:2]; the mod-4 column shift is plain
    // 2-bit wrap-around arithmetic.
    w_src_col  = INVERSE ? (r_rd_cnt[3:2] - r_rd_cnt[1:0])
                         : (r_rd_cnt[3:2] + r_rd_cnt[1:0]);
    w_src      = {w_src_col, r_rd_cnt[1:0]};
    // Byte k sits at bit offset 8*(15-k); for 4-bit k, 15-k is ~k.
    w_rd_lsb   = {~w_src, 3'b000};
    w_wr_lsb   = {~r_wr_cnt, 3'b000};
    out_byte   = r_buf[r_rd_sel][w_rd_lsb +: 8];
    w_state_nxt[0] = buf_next(r_state[0], w_wr_fire && !r_wr_sel,
                              w_rd_fire && !r_rd_sel);
    w_state_nxt[1] = buf_next(r_state[1], w_wr_fire &&  r_wr_sel,
                              w_rd_fire &&  r_rd_sel);
  end

  // Buffer state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state[0] <= BUF_EMPTY;
      r_state[1] <= BUF_EMPTY;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
    end
  end

  // Buffer storage, byte counters and ping-pong selects.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf[0] <= '0;
      r_buf[1] <= '0;
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
    end else begin
      if (w_wr_fire) begin
        r_buf[r_wr_sel][w_wr_lsb +: 8] <= in_byte;
        r_wr_cnt <= r_wr_cnt + 4'd1;
        if (w_wr_last) r_wr_sel <= ~r_wr_sel;
      end
      if (w_rd_fire) begin
        r_rd_cnt <= r_rd_cnt + 4'd1;
        if (w_rd_last) r_rd_sel <= ~r_rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Self-checking bench for inv_shift_rows_serial: directed vectors, stall and
// reset scenarios, and randomized traffic against a row-rotation model.
module tb_inv_shift_rows_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
  logic [7:0] in_byte, out_byte;
  logic       f_in_valid, f_in_ready, f_out_valid, f_out_ready, f_out_last;
  logic [7:0] f_in_byte, f_out_byte;

  inv_shift_rows_serial #(.INVERSE(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last)
  );

  inv_shift_rows_serial #(.INVERSE(1'b0)) u_fwd (
    .clk(clk), .rst_n(rst_n),
    .in_valid(f_in_valid), .in_ready(f_in_ready), .in_byte(f_in_byte),
    .out_valid(f_out_valid), .out_ready(f_out_ready), .out_byte(f_out_byte),
    .out_last(f_out_last)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]   exp_q[$];
  logic [7:0]   got_q[$];
  logic [7:0]   f_got_q[$];
  logic         f_last_q[$];
  logic [127:0] cur_blk = '0;
  int           cur_n   = 0;
  int           out_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [127:0] v, input int k);
    logic [127:0] t;
    t = v << (8 * k);
    return t[127:120];
  endfunction

  // Reference: lay the block out as a 4x4 matrix and rotate row r by r
  // positions (right for the inverse, left for the forward transform).
  function automatic logic [127:0] ref_perm(input logic [127:0] st, input bit inv);
    logic [7:0]   m [4][4];
    logic [7:0]   t;
    logic [127:0] res;
    for (int k = 0; k < 16; k++) m[k[1:0]][k[3:2]] = byte_of(st, k);
    for (int r = 0; r < 4; r++) begin
      for (int s = 0; s < r; s++) begin
        if (inv) begin
          t = m[r][3]; m[r][3] = m[r][2]; m[r][2] = m[r][1]; m[r][1] = m[r][0]; m[r][0] = t;
        end else begin
          t = m[r][0]; m[r][0] = m[r][1]; m[r][1] = m[r][2]; m[r][2] = m[r][3]; m[r][3] = t;
        end
      end
    end
    res = '0;
    for (int k = 0; k < 16; k++) res = {res[119:0], m[k[1:0]][k[3:2]]};
    return res;
  endfunction

  // One clock: observe handshakes mid-cycle, update scoreboard, step past edge.
  task automatic tick();
    logic [127:0] o;
    @(negedge clk);
    if (in_valid && in_ready) begin
      cur_blk = {cur_blk[119:0], in_byte};
      cur_n++;
      if (cur_n == 16) begin
        o = ref_perm(cur_blk, 1'b1);
        for (int k = 0; k < 16; k++) exp_q.push_back(byte_of(o, k));
        cur_n = 0;
      end
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_byte);
      chk("sb_not_extra", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) chk("sb_byte", out_byte, exp_q.pop_front());
      chk("sb_last", out_last, 32'((out_idx % 16) == 15));
      out_idx++;
    end
    if (f_out_valid && f_out_ready) begin
      f_got_q.push_back(f_out_byte);
      f_last_q.push_back(f_out_last);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; f_in_valid = 1'b0; f_out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    exp_q.delete(); got_q.delete(); f_got_q.delete(); f_last_q.delete();
    cur_n = 0; cur_blk = '0; out_idx = 0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_last", out_last, 0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1; in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1; in_byte = b;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) chk("send_timeout", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [7:0] b);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 300) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_byte   = in_valid ? b : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      done      = in_valid && in_ready;
      tick();
      n++;
    end
    if (!done) chk("rand_send_timeout", 32'(done), 1);
    in_valid = 1'b0;
  endtask

  task automatic directed_block(input logic [127:0] vin, input logic [127:0] vexp,
                                input string tag);
    got_q.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      in_byte  = byte_of(vin, k);
      chk({tag, "_in_ready"}, in_ready, 1);
      if (k == 15) chk({tag, "_valid_before_last"}, out_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, out_valid, 1);
    drain();
    chk({tag, "_count"}, got_q.size(), 16);
    for (int k = 0; k < 16; k++)
      chk({tag, "_byte"}, (k < got_q.size()) ? 32'(got_q[k]) : 32'hdead_beef,
          byte_of(vexp, k));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] v, e, blk0, blk1, blk2;
    int n;
    in_byte = '0; f_in_byte = '0;

    // Reset values.
    do_reset();

    // Known-answer vectors for the inverse transform.
    v = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    e = 128'hd42711aee0bf98f1b8b45de51e415230;
    directed_block(v, e, "kat");
    v = 128'h000102030405060708090a0b0c0d0e0f;
    e = 128'h000d0a0704010e0b0805020f0c090603;
    directed_block(v, e, "index");

    // Forward-configuration instance.
    v = 128'hd42711aee0bf98f1b8b45de51e415230;
    e = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    f_out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      f_in_valid = 1'b1;
      f_in_byte  = byte_of(v, k);
      chk("fwd_in_ready", f_in_ready, 1);
      tick();
    end
    f_in_valid = 1'b0;
    n = 0;
    while (f_got_q.size() < 16 && n < 100) begin
      tick();
      n++;
    end
    chk("fwd_count", f_got_q.size(), 16);
    for (int k = 0; k < 16; k++) begin
      chk("fwd_byte", (k < f_got_q.size()) ? 32'(f_got_q[k]) : 32'hdead_beef,
          byte_of(e, k));
      chk("fwd_last", (k < f_last_q.size()) ? 32'(f_last_q[k]) : 32'hdead_beef,
          32'(k == 15));
    end

    // Back-to-back: 4 blocks, in_ready must never drop.
    got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      chk("b2b_in_ready", in_ready, 1);
      tick();
    end
    drain();
    chk("b2b_count", got_q.size(), 64);

    // Backpressure: two blocks fill both buffers, the third stalls.
    got_q.delete();
    blk0 = {$urandom, $urandom, $urandom, $urandom};
    blk1 = {$urandom, $urandom, $urandom, $urandom};
    blk2 = {$urandom, $urandom, $urandom, $urandom};
    e = ref_perm(blk0, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      in_valid = 1'b1;
      in_byte  = (i < 16) ? byte_of(blk0, i) : byte_of(blk1, i - 16);
      chk("bp_in_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b1;
    in_byte  = byte_of(blk2, 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_stall_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_byte_held", out_byte, e[127:120]);
      chk("bp_out_last", out_last, 0);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) send_byte(byte_of(blk2, k));
    drain();
    chk("bp_count", got_q.size(), 48);

    // Reset while block A drains and block B is 7 bytes in.
    v = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) send_byte(byte_of(v, k));
    for (int k = 0; k < 7; k++) send_byte(8'($urandom));
    chk("mid_draining", out_valid, 1);
    do_reset();
    v = {$urandom, $urandom, $urandom, $urandom};
    for (int k = 0; k < 16; k++) send_byte(byte_of(v, k));
    drain();
    chk("post_reset_count", got_q.size(), 16);

    // Randomized traffic: 1000 blocks with random valid/ready.
    got_q.delete();
    for (int b = 0; b < 1000; b++)
      for (int k = 0; k < 16; k++) send_rand(8'($urandom));
    drain();
    chk("rand_count", got_q.size(), 16000);
    chk("rand_partial", cur_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
